// File: rtl/acq_seq_pkg.sv
// Shared definitions for the acquisition trigger sequencer.
//   STATE_WIDTH        width of the status-readback state field
//   DEFAULT_ADDR_WIDTH default DPRAM address width (1024-word ring)
//   acqState_t         capture state encoding, exported on the state port
//   isWriting()        true for the states that write the DPRAM every cycle
package acq_seq_pkg;

  localparam int STATE_WIDTH        = 3;
  localparam int DEFAULT_ADDR_WIDTH = 10;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } acqState_t;

  function automatic logic isWriting(input acqState_t s);
    return (s == FILL) || (s == ARMED) || (s == POST);
  endfunction

endpackage

// File: rtl/acq_trigger_detect.sv
// Trigger qualifier for the acquisition sequencer.
// Ports:
//   adcClk, adcReset  clock and asynchronous active-high reset
//   triggerIn         hardware trigger level, already in the adcClk domain
//   softTrigger       one-cycle software trigger pulse
//   enable            high while the sequencer is waiting for a trigger
//   triggerEvent      single-cycle event: rising edge of triggerIn or softTrigger,
//                     only while enable is high
module acq_trigger_detect (
  input  logic adcClk,
  input  logic adcReset,
  input  logic triggerIn,
  input  logic softTrigger,
  input  logic enable,
  output logic triggerEvent
);

  logic triggerPrev;

  // The previous level is tracked in every state, so a level already high when
  // the sequencer becomes enabled is not mistaken for an edge.
  always_ff @(posedge adcClk or posedge adcReset) begin
    if (adcReset) begin
      triggerPrev <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      triggerPrev <= triggerIn;
    end
  end

  assign triggerEvent = enable & ((triggerIn & ~triggerPrev) | softTrigger);

endmodule

// File: rtl/acq_trigger_sequencer.sv
// Write-side controller for the adcClk-domain acquisition DPRAM. Runs a circular
// capture: fills pretrigCount samples, waits for a trigger, writes posttrigCount
// more samples, then stops and reports where the valid window starts.
// Optional feature macro: TRIGGER_TIMESTAMP_EN adds a free-running cycle counter,
// the TS_WIDTH parameter and the triggerTimestamp output.
// Ports:
//   adcClk, adcReset              clock and asynchronous active-high reset
//   armStrobe, abortStrobe        one-cycle start / cancel pulses
//   pretrigCount, posttrigCount   capture depths, sampled at arm
//   triggerIn, softTrigger        hardware trigger level, software trigger pulse
//   dpramWriteEnable/Address      registered DPRAM write port controls
//   triggerAddress, startAddress  trigger sample address, oldest valid sample
//   busy, done, state             status for the CSR side
//   triggerTimestamp              cycle count of the last trigger (macro only)
module acq_trigger_sequencer
  import acq_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
`ifdef TRIGGER_TIMESTAMP_EN
  , parameter int TS_WIDTH = 32
`endif
) (
  input  logic                   adcClk,
  input  logic                   adcReset,
  input  logic                   armStrobe,
  input  logic                   abortStrobe,
  input  logic [ADDR_WIDTH-1:0]  pretrigCount,
  input  logic [ADDR_WIDTH-1:0]  posttrigCount,
  input  logic                   triggerIn,
  input  logic                   softTrigger,
  output logic                   dpramWriteEnable,
  output logic [ADDR_WIDTH-1:0]  dpramWriteAddress,
  output logic [ADDR_WIDTH-1:0]  triggerAddress,
  output logic [ADDR_WIDTH-1:0]  startAddress,
  output logic                   busy,
  output logic                   done,
  output logic [STATE_WIDTH-1:0] state
`ifdef TRIGGER_TIMESTAMP_EN
  , output logic [TS_WIDTH-1:0]  triggerTimestamp
`endif
);

  acqState_t             stateReg, stateNext;
  logic [ADDR_WIDTH-1:0] pretrigLatched;
  logic [ADDR_WIDTH-1:0] posttrigLatched;
  logic [ADDR_WIDTH-1:0] postCount;
  // One bit wider than the address so the "written so far" comparison cannot wrap.
  logic [ADDR_WIDTH:0]   sampleCount;
  logic                  triggerEvent;
  logic                  armAccept;
  logic                  triggerAccept;

  acq_trigger_detect uTriggerDetect (
    .adcClk       (adcClk),
    .adcReset     (adcReset),
    .triggerIn    (triggerIn),
    .softTrigger  (softTrigger),
    .enable       (stateReg == ARMED),
    .triggerEvent (triggerEvent)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    stateNext     = stateReg;
    armAccept     = 1'b0;
    triggerAccept = 1'b0;
    if (abortStrobe) begin
      // Abort beats a simultaneous arm or trigger.
      stateNext = IDLE;
    end else begin
      unique case (stateReg)
        IDLE, DONE: begin
          if (armStrobe) begin
            stateNext = FILL;
            armAccept = 1'b1;
          end
        end
        FILL: begin
          // Leave once this cycle's write brings the count up to the pre-trigger
          // depth; a depth of 0 still spends one cycle (and one write) here.
          if (sampleCount + (ADDR_WIDTH+1)'(1) >= {1'b0, pretrigLatched}) begin
            stateNext = ARMED;
          end
        end
        ARMED: begin
          if (triggerEvent) begin
            triggerAccept = 1'b1;
            stateNext     = (posttrigLatched == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (postCount == ADDR_WIDTH'(1)) begin
            stateNext = DONE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge adcClk or posedge adcReset) begin
    if (adcReset) begin
      stateReg          <= IDLE;
      dpramWriteEnable  <= 1'b0;
      dpramWriteAddress <= '0;
      triggerAddress    <= '0;
      startAddress      <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      pretrigLatched    <= '0;
      posttrigLatched   <= '0;
      postCount         <= '0;
      sampleCount       <= '0;
    end else begin
      stateReg         <= stateNext;
      // Status flags follow the next state so they change together with state.
      dpramWriteEnable <= isWriting(stateNext);
      busy             <= isWriting(stateNext);
      done             <= (stateNext == DONE);

      // The ring address is never cleared at arm: captures continue around it.
      if (dpramWriteEnable) begin
        dpramWriteAddress <= dpramWriteAddress + 1'b1;
      end

      if (armAccept) begin
        pretrigLatched  <= pretrigCount;
        posttrigLatched <= posttrigCount;
        sampleCount     <= '0;
      end else if (stateReg == FILL) begin
        sampleCount <= sampleCount + 1'b1;
      end

      if (triggerAccept) begin
        triggerAddress <= dpramWriteAddress;
        startAddress   <= dpramWriteAddress - pretrigLatched;
        postCount      <= posttrigLatched;
      end else if (stateReg == POST) begin
        postCount <= postCount - 1'b1;
      end
    end
  end

  assign state = stateReg;

`ifdef TRIGGER_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] tsCounter;

  always_ff @(posedge adcClk or posedge adcReset) begin
    if (adcReset) begin
      tsCounter        <= '0;
      triggerTimestamp <= '0;
    end else begin
      tsCounter <= tsCounter + 1'b1;
      if (triggerAccept) begin
        triggerTimestamp <= tsCounter;
      end
    end
  end
`endif

endmodule

// File: tb/tb_acq_trigger_sequencer.sv
// Randomised scoreboard bench for acq_trigger_sequencer (ADDR_WIDTH=4, 16-word ring).
// Stimulus pushes the expected write stream and completion record for each capture;
// a negedge monitor pops and compares whenever the DUT writes or raises done.
module tb_acq_trigger_sequencer;
  import acq_seq_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int NONE  = 100000;

  logic          adcClk = 1'b0;
  logic          adcReset = 1'b0;
  logic          armStrobe = 1'b0;
  logic          abortStrobe = 1'b0;
  logic [AW-1:0] pretrigCount = '0;
  logic [AW-1:0] posttrigCount = '0;
  logic          triggerIn = 1'b0;
  logic          softTrigger = 1'b0;
  logic          dpramWriteEnable;
  logic [AW-1:0] dpramWriteAddress;
  logic [AW-1:0] triggerAddress;
  logic [AW-1:0] startAddress;
  logic          busy;
  logic          done;
  logic [2:0]    state;
`ifdef TRIGGER_TIMESTAMP_EN
  logic [31:0]   triggerTimestamp;
`endif

  always #5 adcClk = ~adcClk;

  acq_trigger_sequencer #(.ADDR_WIDTH(AW)) dut (
    .adcClk            (adcClk),
    .adcReset          (adcReset),
    .armStrobe         (armStrobe),
    .abortStrobe       (abortStrobe),
    .pretrigCount      (pretrigCount),
    .posttrigCount     (posttrigCount),
    .triggerIn         (triggerIn),
    .softTrigger       (softTrigger),
    .dpramWriteEnable  (dpramWriteEnable),
    .dpramWriteAddress (dpramWriteAddress),
    .triggerAddress    (triggerAddress),
    .startAddress      (startAddress),
    .busy              (busy),
    .done              (done),
    .state             (state)
`ifdef TRIGGER_TIMESTAMP_EN
    , .triggerTimestamp (triggerTimestamp)
`endif
  );

  typedef struct { int addr; int st; } wrExp_t;
  typedef struct { int trig; int start; int addr; longint ts; } doneExp_t;

  wrExp_t   wrQ[$];
  doneExp_t doneQ[$];
  int nChecks = 0;
  int nFails  = 0;
  int ringAddr = 0;   // model: next ring address to be written
  int lastTrig = 0;
  int lastStart = 0;
  int tbCycle = 0;    // cycles since reset release
  logic prevDone = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic checkAllZero(input string name);
    check(name, {dpramWriteEnable, dpramWriteAddress, triggerAddress, startAddress,
                 busy, done, state}, 64'd0);
`ifdef TRIGGER_TIMESTAMP_EN
    check({name, "_ts"}, triggerTimestamp, 64'd0);
`endif
  endtask

  always @(posedge adcClk or posedge adcReset) begin
    if (adcReset) tbCycle <= 0;
    else          tbCycle <= tbCycle + 1;
  end

  // Monitor: consumes expectations whenever the DUT writes or completes.
  always @(negedge adcClk) begin
    if (dpramWriteEnable) begin
      if (wrQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL write_unexpected: got write at addr %0d, expected no write", dpramWriteAddress);
      end else begin
        wrExp_t e;
        e = wrQ.pop_front();
        check("write_addr_state_busy", {dpramWriteAddress, state, busy},
              {e.addr[AW-1:0], e.st[2:0], 1'b1});
      end
    end
    if (done && !prevDone) begin
      if (doneQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL done_unexpected: got done with trig %0d, expected no completion", triggerAddress);
      end else begin
        doneExp_t d;
        d = doneQ.pop_front();
        check("done_record", {triggerAddress, startAddress, dpramWriteAddress, state, busy, dpramWriteEnable},
              {d.trig[AW-1:0], d.start[AW-1:0], d.addr[AW-1:0], 3'd4, 1'b0, 1'b0});
`ifdef TRIGGER_TIMESTAMP_EN
        check("done_timestamp", triggerTimestamp, d.ts[31:0]);
`endif
      end
    end
    prevDone <= done;
  end

  function automatic bit lvl(input int o, input int hs, input int he, input int h2);
    return (o >= hs && o < he) || (o >= h2);
  endfunction

  // Offsets count cycles from the arm cycle (offset 0). The reference model:
  // FILL writes max(p,1) samples; the first trigger event seen while armed is the
  // trigger sample; q samples follow it; done shows the cycle after the last write.
  task automatic runCapture(input int p, input int q, input int softAt, input int hs,
                            input int he, input int h2, input int abortAt, input int resetAt);
    int armedStart, d, total, nWrites, lastOff, trigA, startA;
    bit completes, didReset;
    armedStart = ((p > 1) ? p : 1) + 1;
    d = NONE;
    for (int o = armedStart; o < 300 && d == NONE; o++)
      if ((lvl(o, hs, he, h2) && !lvl(o - 1, hs, he, h2)) || o == softAt) d = o;
    total   = (d == NONE) ? NONE : d + q;
    nWrites = total;
    if (abortAt < nWrites)     nWrites = abortAt;
    if (resetAt - 1 < nWrites) nWrites = resetAt - 1;
    completes = (total < NONE) && (abortAt > total) && (resetAt > total + 1);
    trigA  = (ringAddr + d - 1) % DEPTH;
    startA = (((trigA - p) % DEPTH) + DEPTH) % DEPTH;
    for (int i = 0; i < nWrites; i++) begin
      int o;
      o = i + 1;
      wrQ.push_back('{addr: (ringAddr + i) % DEPTH,
                      st: (o < armedStart) ? int'(FILL) : (o <= d) ? int'(ARMED) : int'(POST)});
    end
    lastOff = total;
    if (abortAt < lastOff) lastOff = abortAt;
    if (resetAt < lastOff) lastOff = resetAt;
    pretrigCount  = AW'(p);
    posttrigCount = AW'(q);
    didReset = 1'b0;
    for (int o = 0; o <= lastOff; o++) begin
      @(posedge adcClk);
      #1;
      if (o == resetAt) begin
        armStrobe = 1'b0; abortStrobe = 1'b0; softTrigger = 1'b0; triggerIn = 1'b0;
        #1 adcReset = 1'b1;
        #1 checkAllZero("reset_mid_capture");
        repeat (2) @(posedge adcClk);
        @(negedge adcClk);
        adcReset = 1'b0;
        @(posedge adcClk);
        #2 check("state_after_reset_release", {state, dpramWriteEnable, done}, {IDLE, 1'b0, 1'b0});
        didReset = 1'b1;
        break;
      end
      if (o == 0 && completes)
        doneQ.push_back('{trig: trigA, start: startA, addr: (ringAddr + total) % DEPTH,
                          ts: longint'(tbCycle + d)});
      armStrobe   = (o == 0);
      abortStrobe = (o == abortAt);
      softTrigger = (o == softAt);
      triggerIn   = lvl(o, hs, he, h2);
    end
    if (didReset) begin
      ringAddr = 0; lastTrig = 0; lastStart = 0;
    end else begin
      @(posedge adcClk);
      #1;
      armStrobe = 1'b0; abortStrobe = 1'b0; softTrigger = 1'b0; triggerIn = 1'b0;
      if (completes || d < abortAt) begin
        lastTrig = trigA; lastStart = startA;
      end
      if (abortAt <= lastOff) begin
        #2 check("abort_to_idle", {state, dpramWriteEnable, busy, done}, {IDLE, 1'b0, 1'b0, 1'b0});
        check("abort_holds_addrs", {triggerAddress, startAddress},
              {lastTrig[AW-1:0], lastStart[AW-1:0]});
      end
      ringAddr = (ringAddr + nWrites) % DEPTH;
    end
    repeat (3) @(posedge adcClk);
    if (completes && !didReset) begin
      #2 check("done_held", {state, done, dpramWriteEnable, dpramWriteAddress},
               {DONE, 1'b1, 1'b0, ringAddr[AW-1:0]});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 adcReset = 1'b1;
    #2 checkAllZero("reset_initial");
    repeat (3) @(posedge adcClk);
    @(negedge adcClk);
    adcReset = 1'b0;
    @(posedge adcClk);
    #2 check("idle_after_release", {state, busy, done}, {IDLE, 1'b0, 1'b0});

    // pretrig 3, post 4 from address 0, soft trigger lands on address 10.
    runCapture(3, 4, 11, NONE, NONE, NONE, NONE, NONE);
    check("basic_trigger_addr", {triggerAddress, startAddress}, {4'd10, 4'd7});

    // Move the ring to 14, then a capture whose window wraps 15 -> 0.
    runCapture(0, 13, 2, NONE, NONE, NONE, NONE, NONE);
    runCapture(2, 3, 4, NONE, NONE, NONE, NONE, NONE);
    check("wrap_trigger_addr", {triggerAddress, startAddress}, {4'd1, 4'd15});

    // triggerIn rises during FILL and stays high into ARMED; only the later edge counts.
    runCapture(3, 2, NONE, 2, 6, 8, NONE, NONE);

    // Minimum capture: one FILL write, trigger sample on the first armed cycle.
    runCapture(0, 0, 2, NONE, NONE, NONE, NONE, NONE);

    // Abort together with arm, then abort in POST.
    runCapture(2, 2, NONE, NONE, NONE, NONE, 0, NONE);
    runCapture(1, 6, 3, NONE, NONE, NONE, 6, NONE);

    // Randomised captures, including depths that overrun the ring.
    for (int n = 0; n < 20; n++) begin
      int p, q, sa, hs;
      p  = $urandom_range(0, 15);
      q  = $urandom_range(0, 15);
      sa = ((p > 1) ? p : 1) + 1 + $urandom_range(0, 3);
      hs = $urandom_range(1, 20);
      runCapture(p, q, sa, hs, hs + $urandom_range(1, 4), NONE, NONE, NONE);
    end

    // Asynchronous reset in the middle of POST, then a fresh capture from address 0.
    runCapture(1, 8, 2, NONE, NONE, NONE, NONE, 5);
    runCapture(2, 5, 6, NONE, NONE, NONE, NONE, NONE);

    check("write_queue_drained", wrQ.size(), 0);
    check("done_queue_drained", doneQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
